// File: rtl/hex_scan_pkg.sv
// Shared types and defaults for the multiplexed hex digit scanner.
// Holds the SCAN/DARK state type and the leading-zero helper.
package hex_scan_pkg;

  localparam int unsigned DEFAULT_NUM_DIGITS = 4;
  localparam int unsigned DEFAULT_PRESCALE   = 50000;
  localparam int unsigned MAX_DIGITS         = 8;

  typedef enum logic {
    SCAN = 1'b0,
    DARK = 1'b1
  } scan_state_e;

  // True when every nibble at position >= first is zero.
  function automatic logic nibbles_zero_from(input logic [4*MAX_DIGITS-1:0] value,
                                             input int unsigned first);
    logic zero;
    zero = 1'b1;
    for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
      if (k >= first && value[4*k +: 4] != 4'h0) begin
        zero = 1'b0;
      end
    end
    return zero;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Slot prescaler: counts 0..PRESCALE-1 and flags the terminal count.
// clear holds the count at zero, e.g. while the display is dark.
module tick_gen
  import hex_scan_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] Terminal = CntW'(PRESCALE - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == Terminal) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign tick = (r_cnt == Terminal);

endmodule

// File: rtl/hex_digit_scanner.sv
// Time-multiplexed hex display scanner with a one-deep pending buffer swapped in at frame ends.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module hex_digit_scanner
  import hex_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int unsigned PRESCALE   = DEFAULT_PRESCALE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  output logic                    in_ready,
  input  logic                    blank,
  output logic [3:0]              hex_out,
  output logic [NUM_DIGITS-1:0]   digit_en
);

  localparam int unsigned DataW = 4 * NUM_DIGITS;
  localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

  scan_state_e           r_state;
  scan_state_e           w_state_nxt;
  logic [IdxW-1:0]       r_index;
  logic [IdxW-1:0]       w_index_nxt;
  logic [DataW-1:0]      r_display;
  logic [DataW-1:0]      w_display_nxt;
  logic [DataW-1:0]      r_pending;
  logic [DataW-1:0]      w_pending_nxt;
  logic                  r_pend_full;
  logic                  w_pend_full_nxt;
  logic [3:0]            r_hex_out;
  logic [3:0]            w_hex_nxt;
  logic [NUM_DIGITS-1:0] r_digit_en;
  logic [NUM_DIGITS-1:0] w_digit_en_nxt;

  logic w_tick;
  logic w_clear;
  logic w_boundary;
  logic w_accept;

  // Prescaler is frozen at zero while dark and on the cycle blanking starts.
  assign w_clear = (r_state == DARK) || blank;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(w_clear),
    .tick (w_tick)
  );

  // Pending buffer and display swap.
  always_comb begin
    w_boundary      = (r_state == SCAN) && w_tick && (r_index == LastIdx);
    w_accept        = in_valid && !r_pend_full;
    w_display_nxt   = r_display;
    w_pending_nxt   = r_pending;
    w_pend_full_nxt = r_pend_full;
    // Swap only data that was already pending; a same-cycle accept waits a frame.
    if (w_boundary && r_pend_full) begin
      w_display_nxt   = r_pending;
      w_pend_full_nxt = 1'b0;
    end else if (w_accept) begin
      w_pending_nxt   = in_data;
      w_pend_full_nxt = 1'b1;
    end
  end

  // Scan state and digit index.
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    case (r_state)
      SCAN: begin
        if (blank) begin
          w_state_nxt = DARK;
          w_index_nxt = '0;
        end else if (w_tick) begin
          w_index_nxt = (r_index == LastIdx) ? '0 : r_index + IdxW'(1);
        end
      end
      DARK: begin
        w_index_nxt = '0;
        if (!blank) begin
          w_state_nxt = SCAN;
        end
      end
      default: begin
        w_state_nxt = SCAN;
        w_index_nxt = '0;
      end
    endcase
  end

  // Outputs are computed from next state and registered, so the decoder sees no glitches.
  always_comb begin
    w_hex_nxt      = w_display_nxt[4*w_index_nxt +: 4];
    w_digit_en_nxt = '0;
    if (w_state_nxt == SCAN) begin
      w_digit_en_nxt[w_index_nxt] = 1'b1;
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (w_index_nxt != '0 && nibbles_zero_from(32'(w_display_nxt), 32'(w_index_nxt))) begin
      w_digit_en_nxt = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SCAN;
      r_index     <= '0;
      r_display   <= '0;
      r_pending   <= '0;
      r_pend_full <= 1'b0;
      r_hex_out   <= 4'h0;
      r_digit_en  <= NUM_DIGITS'(1);
    end else begin
      r_state     <= w_state_nxt;
      r_index     <= w_index_nxt;
      r_display   <= w_display_nxt;
      r_pending   <= w_pending_nxt;
      r_pend_full <= w_pend_full_nxt;
      r_hex_out   <= w_hex_nxt;
      r_digit_en  <= w_digit_en_nxt;
    end
  end

  assign in_ready = !r_pend_full;
  assign hex_out  = r_hex_out;
  assign digit_en = r_digit_en;

endmodule
